// File: rtl/knn_pkg.sv
// knn_pkg -- shared definitions for the kNN classification controller.
//   knn_state_e : controller FSM state encoding
//   KNN_*_DEF   : default values for the L / K / W / T parameters
//   knn_clog2() : index-width helper, never returns less than 1 bit
package knn_pkg;

  localparam int unsigned KNN_L_DEF = 15;  // training samples
  localparam int unsigned KNN_K_DEF = 7;   // neighbours voted
  localparam int unsigned KNN_W_DEF = 32;  // data / type word width
  localparam int unsigned KNN_T_DEF = 4;   // valid class types

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_READ,
    ST_CALC_GO,
    ST_CALC_WAIT,
    ST_SORT_GO,
    ST_SORT_WAIT,
    ST_VOTE,
    ST_RESOLVE,
    ST_WRITE,
    ST_DONE
  } knn_state_e;

  // ceil(log2(v)), floored at 1 so that a depth of 1 still gets a real
  // one-bit index instead of a zero-width vector.
  function automatic int unsigned knn_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/knn_vote.sv
// knn_vote -- per-type vote counters and argmax for the kNN controller.
//   clk, rst      : clock, synchronous active-low reset
//   clr_i         : clear all counters (pulsed on the edge into VOTE)
//   en_i          : count vote_type_i this cycle (high throughout VOTE)
//   vote_type_i   : type of the current sorted neighbour
//   winner_o      : type with the highest count, lowest type on ties,
//                   0 when every count is 0 (combinational)
module knn_vote
  import knn_pkg::*;
#(
  parameter int unsigned K = KNN_K_DEF,
  parameter int unsigned W = KNN_W_DEF,
  parameter int unsigned T = KNN_T_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] vote_type_i,
  output logic [W-1:0] winner_o
);

  // A count can reach K at most, so K+1 values never overflow.
  localparam int unsigned CW = knn_clog2(K + 1);
  localparam int unsigned TW = knn_clog2(T);

  logic [CW-1:0] cnt_q [T];
  logic          hit;

  // Out-of-range types (>= T) simply do not vote.
  assign hit = en_i && (vote_type_i < W'(T));

  for (genvar t = 0; t < T; t++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (!rst) begin
        cnt_q[t] <= '0;
      end else if (clr_i) begin
        cnt_q[t] <= '0;
      end else if (hit && (vote_type_i == W'(t))) begin
        cnt_q[t] <= cnt_q[t] + CW'(1);
      end
    end
  end

  // Strict '>' while scanning upwards keeps the lowest type on a tie and
  // leaves type 0 as the answer when nothing was counted.
  logic [TW-1:0] best_idx;
  logic [CW-1:0] best_cnt;

  always_comb begin
    best_idx = '0;
    best_cnt = cnt_q[0];
    for (int t = 1; t < T; t++) begin
      if (cnt_q[t] > best_cnt) begin
        best_cnt = cnt_q[t];
        best_idx = TW'(t);
      end
    end
  end

  assign winner_o = W'(best_idx);

endmodule

// File: rtl/knn_controller.sv
// knn_controller -- sequences a k-nearest-neighbour classification job:
// fetch each of L training samples, run the distance calculator on it,
// sort the distances, vote over the K nearest types and write the class.
//   clk, rst                 : clock, synchronous active-low reset
//   start / busy / done      : job request, active status, 1-cycle complete
//   read, read_done, rd_idx  : training-sample fetch handshake and index
//   calc_start / calc_done   : distance calculator handshake
//   sort_start / sort_done   : distance sorter handshake
//   vote_idx / vote_type     : lookup into the sorted type array
//   class_out, write, write_done : result and its write-back handshake
// Build option: KNN_VOTE_EN enables the VOTE/RESOLVE phases (knn_vote);
// without it the sorter completion goes straight to WRITE and class_out
// and vote_idx are tied to 0.
module knn_controller
  import knn_pkg::*;
#(
  parameter int unsigned L = KNN_L_DEF,
  parameter int unsigned K = KNN_K_DEF,
  parameter int unsigned W = KNN_W_DEF,
  parameter int unsigned T = KNN_T_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     read,
  input  logic                     read_done,
  output logic [knn_clog2(L)-1:0]  rd_idx,
  output logic                     calc_start,
  input  logic                     calc_done,
  output logic                     sort_start,
  input  logic                     sort_done,
  output logic [knn_clog2(K)-1:0]  vote_idx,
  input  logic [W-1:0]             vote_type,
  output logic [W-1:0]             class_out,
  output logic                     write,
  input  logic                     write_done
);

  localparam int unsigned RW = knn_clog2(L);
  localparam int unsigned VW = knn_clog2(K);

  knn_state_e    state_q, state_d;
  logic [RW-1:0] rd_idx_q, rd_idx_d;
  logic          last_smp;

  assign last_smp = (rd_idx_q == RW'(L - 1));

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_idx_q <= rd_idx_d;
    end
  end

`ifdef KNN_VOTE_EN
  logic [VW-1:0] vote_idx_q, vote_idx_d;
  logic [W-1:0]  class_q, class_d;
  logic [W-1:0]  winner;
  logic          last_vote;

  assign last_vote = (vote_idx_q == VW'(K - 1));
`endif

  // ----------------------------------------------------------- next state
  always_comb begin
    state_d  = state_q;
    rd_idx_d = rd_idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_READ;
          rd_idx_d = '0;
        end
      end
      ST_READ:      if (read_done) state_d = ST_CALC_GO;
      ST_CALC_GO:   state_d = ST_CALC_WAIT;
      ST_CALC_WAIT: begin
        if (calc_done) begin
          if (last_smp) begin
            state_d = ST_SORT_GO;
          end else begin
            state_d  = ST_READ;
            rd_idx_d = rd_idx_q + RW'(1);
          end
        end
      end
      ST_SORT_GO:   state_d = ST_SORT_WAIT;
`ifdef KNN_VOTE_EN
      ST_SORT_WAIT: if (sort_done) state_d = ST_VOTE;
      ST_VOTE:      if (last_vote) state_d = ST_RESOLVE;
      ST_RESOLVE:   state_d = ST_WRITE;
`else
      ST_SORT_WAIT: if (sort_done) state_d = ST_WRITE;
`endif
      ST_WRITE:     if (write_done) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------- outputs
  always_comb begin
    busy       = (state_q != ST_IDLE);
    read       = 1'b0;
    calc_start = 1'b0;
    sort_start = 1'b0;
    write      = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      ST_READ:    read       = 1'b1;
      ST_CALC_GO: calc_start = 1'b1;
      ST_SORT_GO: sort_start = 1'b1;
      ST_WRITE:   write      = 1'b1;
      ST_DONE:    done       = 1'b1;
      default:    ;
    endcase
  end

  assign rd_idx = rd_idx_q;

`ifdef KNN_VOTE_EN
  // ----------------------------------------------------------------- vote
  logic vote_clr, vote_en;

  // Clearing on the entry edge means the first VOTE cycle already sees
  // zeroed counters and can count straight away.
  assign vote_clr = (state_q == ST_SORT_WAIT) && sort_done;
  assign vote_en  = (state_q == ST_VOTE);

  always_comb begin
    vote_idx_d = vote_idx_q;
    if (vote_clr)     vote_idx_d = '0;
    else if (vote_en) vote_idx_d = last_vote ? '0 : vote_idx_q + VW'(1);
  end

  // class_out only changes in RESOLVE and holds across later jobs' phases.
  assign class_d = (state_q == ST_RESOLVE) ? winner : class_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vote_idx_q <= '0;
      class_q    <= '0;
    end else begin
      vote_idx_q <= vote_idx_d;
      class_q    <= class_d;
    end
  end

  knn_vote #(.K(K), .W(W), .T(T)) u_vote (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (vote_clr),
    .en_i        (vote_en),
    .vote_type_i (vote_type),
    .winner_o    (winner)
  );

  assign vote_idx  = vote_idx_q;
  assign class_out = class_q;
`else
  logic unused_vote_type;

  assign unused_vote_type = ^vote_type;
  assign vote_idx         = '0;
  assign class_out        = '0;
`endif

endmodule

// File: tb/tb_knn_controller.sv
// tb_knn_controller -- directed self-checking bench for knn_controller
// (L=15, K=7, W=32, T=4). Handshakes are answered by an in-bench responder;
// expected cycle counts and classes are hand-computed for both builds.
module tb_knn_controller;

  localparam int unsigned L = 15;
  localparam int unsigned K = 7;
  localparam int unsigned W = 32;
  localparam int unsigned T = 4;

`ifdef KNN_VOTE_EN
  // READ 2 + CALC_GO 1 + CALC_WAIT 1 per sample, SORT 2, VOTE 7 + RESOLVE 1,
  // WRITE 2, DONE 1
  localparam int EXP_BUSY_NORM = 73;
  localparam int EXP_BUSY_FAST = 58;  // READ is 1 cycle per sample
  localparam int EXP_SW_LAT    = 9;   // sort_done -> write: 7 VOTE + RESOLVE + 1
  localparam int EXP_CLASS_A   = 2;
  localparam int EXP_CLASS_B   = 1;
`else
  localparam int EXP_BUSY_NORM = 65;
  localparam int EXP_BUSY_FAST = 50;
  localparam int EXP_SW_LAT    = 1;
  localparam int EXP_CLASS_A   = 0;
  localparam int EXP_CLASS_B   = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         read_done = 1'b0;
  logic         calc_done = 1'b0;
  logic         sort_done = 1'b0;
  logic         write_done = 1'b0;
  logic         busy, done, read, calc_start, sort_start, write;
  logic [3:0]   rd_idx;
  logic [2:0]   vote_idx;
  logic [W-1:0] vote_type;
  logic [W-1:0] class_out;
  logic [W-1:0] vtab [8];

  assign vote_type = vtab[vote_idx];

  knn_controller #(.L(L), .K(K), .W(W), .T(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .read       (read),
    .read_done  (read_done),
    .rd_idx     (rd_idx),
    .calc_start (calc_start),
    .calc_done  (calc_done),
    .sort_start (sort_start),
    .sort_done  (sort_done),
    .vote_idx   (vote_idx),
    .vote_type  (vote_type),
    .class_out  (class_out),
    .write      (write),
    .write_done (write_done)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_votes(input int a0, a1, a2, a3, a4, a5, a6);
    vtab[0] = W'(a0); vtab[1] = W'(a1); vtab[2] = W'(a2); vtab[3] = W'(a3);
    vtab[4] = W'(a4); vtab[5] = W'(a5); vtab[6] = W'(a6); vtab[7] = '0;
  endtask

  // per-job observations
  int j_done, j_busy, j_reads, j_rdbad, j_nrd, j_sw_lat;
  bit j_timeout;

  // Runs one job. fast: read_done held high. inject: calc_done pulsed in
  // the first READ cycle and start pulsed in SORT_WAIT. abort_idx >= 0:
  // pull rst low during CALC_WAIT of that sample and stop.
  task automatic run_job(input bit fast, input bit inject, input int abort_idx);
    bit p_read = 0, p_calc = 0, p_sort = 0, p_write = 0;
    bit fin = 0;
    int cyc = 0, sd_cyc = -1;
    j_done = 0; j_busy = 0; j_reads = 0; j_rdbad = 0; j_nrd = 0;
    j_sw_lat = -1; j_timeout = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!fin && cyc < 400) begin
      cyc++;
      if (busy) j_busy++;
      if (done) begin j_done++; fin = 1; end
      if (read) j_reads++;
      if (read && !p_read) begin
        if (rd_idx != 4'(j_nrd)) j_rdbad++;
        j_nrd++;
      end
      if (write && !p_write && sd_cyc >= 0 && j_sw_lat < 0) j_sw_lat = cyc - sd_cyc;
      // responses, one cycle after each request
      read_done  = fast ? 1'b1 : (read && p_read);
      calc_done  = p_calc;
      if (inject && read && !p_read) calc_done = 1'b1;
      sort_done  = p_sort;
      if (p_sort) sd_cyc = cyc;
      start      = inject && p_sort;
      write_done = write && p_write;
      if (abort_idx >= 0 && p_calc && rd_idx == 4'(abort_idx)) begin
        calc_done = 1'b0;
        rst       = 1'b0;
        fin       = 1;
      end
      p_read = read; p_calc = calc_start; p_sort = sort_start; p_write = write;
      tick();
    end
    if (!fin) j_timeout = 1;
    start = 1'b0; read_done = 1'b0; calc_done = 1'b0;
    sort_done = 1'b0; write_done = 1'b0;
  endtask

  initial begin
    set_votes(0, 0, 0, 0, 0, 0, 0);
    // ------------------------------------------------------------- reset
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_read", read, 0);
    chk("rst_calc", calc_start, 0);
    chk("rst_sort", sort_start, 0);
    chk("rst_write", write, 0);
    chk("rst_rdidx", rd_idx, 0);
    chk("rst_vidx", vote_idx, 0);
    chk("rst_class", class_out, 0);
    rst = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // ------------------------------------ job A: 1-cycle-late handshakes
    set_votes(2, 1, 2, 3, 1, 2, 0);
    run_job(0, 0, -1);
    chk("A_timeout", j_timeout, 0);
    chk("A_done_once", j_done, 1);
    chk("A_busy_cycles", j_busy, EXP_BUSY_NORM);
    chk("A_read_cycles", j_reads, 2 * L);
    chk("A_rd_seq_bad", j_rdbad, 0);
    chk("A_rd_seq_cnt", j_nrd, L);
    chk("A_sort_to_write", j_sw_lat, EXP_SW_LAT);
    chk("A_class", class_out, EXP_CLASS_A);
    tick();
    chk("A_idle_after", busy, 0);
    chk("A_no_done_after", done, 0);
    chk("A_class_hold", class_out, EXP_CLASS_A);

    // ------------------------------ job B: read_done held, tie vote + junk
    set_votes(1, 3, 3, 1, 0, 5, 5);
    run_job(1, 0, -1);
    chk("B_timeout", j_timeout, 0);
    chk("B_done_once", j_done, 1);
    chk("B_busy_cycles", j_busy, EXP_BUSY_FAST);
    chk("B_read_cycles", j_reads, L);
    chk("B_rd_seq_bad", j_rdbad, 0);
    chk("B_rd_seq_cnt", j_nrd, L);
    chk("B_class", class_out, EXP_CLASS_B);

    // --------------------------------- mid-job reset in CALC_WAIT, idx 6
    set_votes(2, 1, 2, 3, 1, 2, 0);
    run_job(0, 0, 6);
    chk("R_reached", j_timeout, 0);
    chk("R_rd_before", j_nrd, 7);
    chk("R_busy", busy, 0);
    chk("R_read", read, 0);
    chk("R_calc", calc_start, 0);
    chk("R_sort", sort_start, 0);
    chk("R_write", write, 0);
    chk("R_done", done, 0);
    chk("R_rdidx", rd_idx, 0);
    chk("R_vidx", vote_idx, 0);
    chk("R_class", class_out, 0);
    rst = 1'b1;
    begin
      int dn = 0;
      int bz = 0;
      repeat (10) begin
        tick();
        if (done) dn++;
        if (busy) bz++;
      end
      chk("R_no_done", dn, 0);
      chk("R_stays_idle", bz, 0);
    end

    // ------- job C: restart, stray calc_done in READ, start in SORT_WAIT
    run_job(0, 1, -1);
    chk("C_timeout", j_timeout, 0);
    chk("C_done_once", j_done, 1);
    chk("C_busy_cycles", j_busy, EXP_BUSY_NORM);
    chk("C_rd_seq_bad", j_rdbad, 0);
    chk("C_rd_seq_cnt", j_nrd, L);
    chk("C_class", class_out, EXP_CLASS_A);
    tick();
    chk("C_idle_after", busy, 0);
    tick();
    chk("C_no_restart", busy, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/knn_controller.md
KNN_CONTROLLER -- requirements
Module: knn_controller

Interface
REQ-001 SHALL have parameter L, default 15: number of training samples.
REQ-002 SHALL have parameter K, default 7: neighbours voted; 1 <= K <= L.
REQ-003 SHALL have parameter W, default 32: data and type word width.
REQ-004 SHALL have parameter T, default 4: number of valid class types.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have ports start (in, 1) and busy (out, 1): job request and active status.
REQ-008 SHALL have port done, output, 1 bit: one-cycle job-complete pulse.
REQ-009 SHALL have ports read (out, 1), read_done (in, 1), and rd_idx (out, clog2(L)): fetch of training sample rd_idx.
REQ-010 SHALL have ports calc_start (out, 1) and calc_done (in, 1): distance calculator handshake.
REQ-011 SHALL have ports sort_start (out, 1) and sort_done (in, 1): distance sorter handshake.
REQ-012 SHALL have ports vote_idx (out, clog2(K)) and vote_type (in, W): sorted type array lookup, combinational.
REQ-013 SHALL have ports class_out (out, W), write (out, 1), and write_done (in, 1): result write-back handshake.

Function
REQ-014 SHALL implement the FSM states IDLE, READ, CALC_GO, CALC_WAIT, SORT_GO, SORT_WAIT, VOTE, RESOLVE, WRITE, and DONE.
REQ-015 SHALL move IDLE->READ on start=1, with rd_idx cleared to 0; start SHALL be ignored in all other states.
REQ-016 SHALL hold read=1 throughout READ; read_done=1 in any READ cycle, including the first, SHALL move READ->CALC_GO.
REQ-017 SHALL assert calc_start for the single CALC_GO cycle, then move to CALC_WAIT.
REQ-018 SHALL sample calc_done only in CALC_WAIT; on calc_done=1, the FSM SHALL go to SORT_GO if rd_idx==L-1, else increment rd_idx and go to READ.
REQ-019 SHALL pulse sort_start for one cycle in SORT_GO; on sort_done=1 in SORT_WAIT, the FSM SHALL go to VOTE.
REQ-020 SHALL spend exactly K cycles in VOTE, with vote_idx running 0..K-1, incrementing the count for vote_type when vote_type<T and ignoring vote_type>=T.
REQ-021 SHALL, in the single RESOLVE cycle, register into class_out the type with the highest count, breaking ties by the lowest type value; if all counts are 0, class_out SHALL be 0.
REQ-022 SHALL hold write=1 throughout WRITE; write_done=1 SHALL move WRITE->DONE.
REQ-023 SHALL pulse done for one cycle in DONE, then return to IDLE; class_out SHALL hold until the next RESOLVE.
REQ-024 SHALL drive busy=1 in every state except IDLE.
REQ-025 SHALL ignore handshake inputs outside their wait states; no errors are flagged.
REQ-026 SHALL not increment rd_idx beyond L-1 (no wrap); per-type counters SHALL be clog2(K+1) bits wide, so they never overflow.
REQ-027 SHALL clear vote counters on VOTE entry.

Reset
REQ-028 SHALL, with rst=0 at a clock edge in any state including mid-job, force state to IDLE.
REQ-029 SHALL, on that reset, force busy, done, read, calc_start, sort_start, and write to 0, and force rd_idx, vote_idx, class_out, and all counters to 0.

Configuration
REQ-030 SHALL, with KNN_VOTE_EN defined, implement VOTE and RESOLVE as specified.
REQ-031 SHALL, without KNN_VOTE_EN, go SORT_WAIT->WRITE on sort_done, tie class_out and vote_idx to 0, and omit vote counter logic.

Structure
REQ-032 SHALL place the state enumeration, default parameter values, and a clog2 helper in the shared package knn_pkg.
REQ-033 SHALL implement the vote counters and argmax in the sub-module knn_vote, instantiated only under KNN_VOTE_EN.

Verification
REQ-034 SHALL verify the basic job: L=15, K=7, T=4, with every handshake answered one cycle after its request; done SHALL be seen exactly once, and busy SHALL be high from the cycle after start until DONE.
REQ-035 SHALL verify that with read_done held at 1 the whole job, each READ lasts 1 cycle and rd_idx steps 0..14 with no skip or repeat.
REQ-036 SHALL verify the vote: vote_type sequence 2,1,2,3,1,2,0 gives class_out=2; sequence 1,3,3,1,0,5,5 gives class_out=1 (tie broken low, 5 ignored).
REQ-037 SHALL verify reset mid-job: rst=0 for one cycle during CALC_WAIT with rd_idx=6 gives IDLE, all outputs 0, and no done; a following start restarts at rd_idx=0.
REQ-038 SHALL verify that start pulsed during SORT_WAIT is ignored, and that calc_done pulsed during READ does not advance the FSM.
REQ-039 SHALL verify that a build without KNN_VOTE_EN goes sort_done -> write asserted on the next cycle, with class_out=0.
